hazard_forward_unit: RTL and testbench
======================================

# hazard_forward_unit

Parametrised hazard and forwarding unit for the in-order ARM pipeline, sitting beside the ID stage. It keeps its own scoreboard of the instructions in flight between EXE and WB, so the EXE/MEM pipeline registers do not need to export their destination and write-enable fields. Each cycle it decides whether the ID instruction must stall and, when forwarding is compiled in, which in-flight stage supplies each source operand. It also counts stall cycles for performance analysis.

## Interface
- `REG_ADDR_W`, default 4: register-address width; 16 architectural registers.
- `STAGES`, default 2: number of tracked stages between ID and WB. Stage 0 = EXE, stage 1 = MEM, and so on up to `STAGES-1`.
- `LOAD_LAT`, default 1: a load's result can be forwarded only once the load sits in stage index ≥ `LOAD_LAT`. Must be in 1..`STAGES`.
- `CNT_W`, default 16: width of the stall counter.
- `clk` in 1: clock. Everything is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `freeze` in 1: the whole pipeline is held (memory wait); the scoreboard and counter hold.
- `flush` in 1: branch taken; all in-flight entries are cleared at the next edge.
- `id_valid` in 1: the ID stage holds a real instruction.
- `id_wb_en` in 1: the ID instruction writes a register.
- `id_dest` in `REG_ADDR_W`: destination of the ID instruction.
- `id_mem_read` in 1: the ID instruction is a load.
- `src_1` in `REG_ADDR_W`: first source (Rn).
- `src_2` in `REG_ADDR_W`: second source.
- `two_src` in 1: `src_2` is used.
- `hazard_detected` out 1: stall ID/IF this cycle and issue a bubble.
- `fwd_sel_1`, `fwd_sel_2` out `$clog2(STAGES+1)`: operand source. 0 = register file; k = result of stage k-1.
- `stall_count` out `CNT_W`: saturating count of stall cycles.

## Operation
- Scoreboard: `STAGES` entries, each {valid, wb_en, dest, is_load}. Entry i mirrors the instruction currently in stage i.
- Edge update, in priority order:
  - `rst` or `flush`: all entries invalid.
  - else `freeze`: hold all entries.
  - else shift: entry[i] <= entry[i-1] for i ≥ 1. Entry[0] <= ID fields when `id_valid` & !`hazard_detected`, otherwise a bubble (valid=0).
- Match for a source s at stage i: entry[i].valid & entry[i].wb_en & entry[i].dest == s. `src_2` is considered only when `two_src` = 1.
- With forwarding: for each used source, take the lowest-index matching stage i (the youngest producer wins).
  - If that entry is a load and i < `LOAD_LAT`: `hazard_detected` = 1 and fwd_sel = 0.
  - Otherwise fwd_sel = i+1.
  - No match: fwd_sel = 0.
- `hazard_detected` is the OR over both sources and is gated by `id_valid`.
- `hazard_detected`, `fwd_sel_*` are combinational from the scoreboard and current ID inputs, with no added latency.
- `stall_count` increments on each edge where `hazard_detected` & !`freeze` & !`flush` & !`rst`. It saturates at all-ones.

## Timing
- Reset values: scoreboard all invalid, `stall_count` = 0, `hazard_detected` = 0, `fwd_sel_1` = `fwd_sel_2` = 0.
- Load-use case (`LOAD_LAT`=1): a load in EXE with a dependent instruction in ID gives exactly 1 stall cycle. The next cycle returns fwd_sel = 2 (MEM).
- Back-to-back ALU dependency: 0 stall cycles, fwd_sel = 1.
- Producer leaves stage `STAGES-1` (into WB): no longer matched. The register file (write-first) supplies the value.
- Stall during `freeze`: the output stays asserted, the scoreboard does not shift, and `stall_count` does not increment.
- `flush` together with a stall: the entries clear, and next cycle the stall drops.
- `flush` together with `freeze`: `flush` wins.
- `rst` mid-stall: the next cycle the outputs are at their reset values.

## Configuration
- `HAZARD_FORWARDING_EN` defined: forwarding behaviour as above.
- `HAZARD_FORWARDING_EN` undefined:
  - `hazard_detected` = 1 on any match in any stage, load or not.
  - `fwd_sel_1`/`fwd_sel_2` tied to 0.
  - Scoreboard and counter are unchanged.
  - This equals the first-generation stall-only behaviour, generalised to `STAGES`.

## Structure
- Package `hazard_pkg`:
  - `sb_entry_t` struct {valid, wb_en, dest, is_load}.
  - Constant `FWD_RF` = 0.
  - Function `fwd_w(STAGES)` returning the `fwd_sel` width.
- Sub-module `hazard_src_match` (one instance per source):
  - Inputs: scoreboard vector, source address, use flag.
  - Outputs: hit, youngest hit index, load-too-early flag.

## Test plan
- ALU write r3 issued, next ID reads `src_1`=3 → `hazard_detected`=0, `fwd_sel_1`=1. One cycle later, with an unrelated instruction between, → `fwd_sel_1`=2.
- Load to r5, then ID reads `src_2`=5 with `two_src`=1 → 1 stall cycle, `stall_count` 0→1, then `fwd_sel_2`=2. Same with `two_src`=0 → no stall.
- r4 written in both EXE and MEM, ID reads r4 → `fwd_sel_1`=1 (youngest producer).
- Load-use stall with `freeze` held 3 cycles → stall stays high, `stall_count` unchanged; after release the load advances and the stall drops.
- `flush` while a load-use stall is pending → the next cycle all entries are invalid, `hazard_detected`=0, `fwd_sel`=0.
- Build without `HAZARD_FORWARDING_EN`: ALU write r2 then read r2 → stall for `STAGES` cycles (2), then proceed with `fwd_sel`=0. Force `stall_count` to all-ones minus 1 and run 3 stalls → it holds at all-ones.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard/forwarding unit.
// Optional feature macro: HAZARD_FORWARDING_EN (forwarding paths; default build is stall-only).
package hazard_pkg;

  // Scoreboard destination field width; must be >= REG_ADDR_W of any instance.
  localparam int SB_DEST_W = 8;

  // fwd_sel encoding for "take the operand from the register file".
  localparam int FWD_RF = 0;

  // One in-flight instruction as seen by the hazard logic.
  typedef struct packed {
    logic                 valid;
    logic                 wb_en;
    logic [SB_DEST_W-1:0] dest;
    logic                 is_load;
  } sb_entry_t;

  // Width of fwd_sel: encodes 0 (register file) plus one code per tracked stage.
  function automatic int fwd_w(input int stages);
    return (stages < 1) ? 1 : $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/hazard_forward_unit_if.sv
// ID-stage side-band bundle between the pipeline control and the hazard/forwarding unit.
// Optional feature macro: HAZARD_FORWARDING_EN (affects only how fwd_sel_* is driven).
interface hazard_forward_unit_if
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 4,
  parameter int STAGES     = 2,
  parameter int CNT_W      = 16
) ();

  localparam int FW = fwd_w(STAGES);

  logic                  freeze;
  logic                  flush;
  logic                  id_valid;
  logic                  id_wb_en;
  logic [REG_ADDR_W-1:0] id_dest;
  logic                  id_mem_read;
  logic [REG_ADDR_W-1:0] src_1;
  logic [REG_ADDR_W-1:0] src_2;
  logic                  two_src;
  logic                  hazard_detected;
  logic [FW-1:0]         fwd_sel_1;
  logic [FW-1:0]         fwd_sel_2;
  logic [CNT_W-1:0]      stall_count;

  // Pipeline control side: drives ID information, consumes stall/forward decisions.
  modport master (
    output freeze, flush, id_valid, id_wb_en, id_dest, id_mem_read,
    output src_1, src_2, two_src,
    input  hazard_detected, fwd_sel_1, fwd_sel_2, stall_count
  );

  // Hazard unit side.
  modport slave (
    input  freeze, flush, id_valid, id_wb_en, id_dest, id_mem_read,
    input  src_1, src_2, two_src,
    output hazard_detected, fwd_sel_1, fwd_sel_2, stall_count
  );

endinterface

// File: rtl/hazard_src_match.sv
// Finds the youngest in-flight producer of one source operand.
// Optional feature macro: HAZARD_FORWARDING_EN (not used here; the caller decides how to use the flags).
module hazard_src_match
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 4,
  parameter int STAGES     = 2,
  parameter int LOAD_LAT   = 1,
  parameter int IDX_W      = fwd_w(STAGES)
) (
  input  sb_entry_t [STAGES-1:0] i_sb,
  input  logic [REG_ADDR_W-1:0]  i_src,
  input  logic                   i_use,
  output logic                   o_hit,
  output logic [IDX_W-1:0]       o_idx,
  output logic                   o_too_early
);

  // Scan oldest to youngest so the lowest-index (youngest) match is the one left standing.
  always_comb begin
    // NOTE: every output gets a default before any condition, otherwise a path that skips the assignment infers a latch.
    o_hit       = 1'b0;
    o_idx       = '0;
    o_too_early = 1'b0;
    if (i_use) begin
      for (int i = STAGES - 1; i >= 0; i--) begin
        if (i_sb[i].valid && i_sb[i].wb_en && (i_sb[i].dest == SB_DEST_W'(i_src))) begin
          o_hit       = 1'b1;
          o_idx       = IDX_W'(i);
          o_too_early = i_sb[i].is_load && (i < LOAD_LAT);
        end
      end
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand forwarding beside the ID stage, with a private
// scoreboard of the instructions between EXE and WB and a saturating stall counter.
// Optional feature macro: HAZARD_FORWARDING_EN
//   defined   : forward from the youngest producer, stall only on a load that is too young.
//   undefined : stall on any in-flight producer; fwd_sel_* tied to the register file.
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 4,
  parameter int STAGES     = 2,
  parameter int LOAD_LAT   = 1,
  parameter int CNT_W      = 16
) (
  input logic                  clk,
  input logic                  rst,
  hazard_forward_unit_if.slave bus
);

  localparam int FW = fwd_w(STAGES);

  sb_entry_t [STAGES-1:0] r_sb;
  logic [CNT_W-1:0]       r_stall_count;

  sb_entry_t       w_id_entry;
  logic            w_hazard;
  logic            w_hit_1;
  logic            w_hit_2;
  logic            w_early_1;
  logic            w_early_2;
  logic [FW-1:0]   w_idx_1;
  logic [FW-1:0]   w_idx_2;
  logic [FW-1:0]   w_fwd_1;
  logic [FW-1:0]   w_fwd_2;

  // src_1 (Rn) is always read; src_2 only when the instruction has two sources.
  hazard_src_match #(
    .REG_ADDR_W (REG_ADDR_W),
    .STAGES     (STAGES),
    .LOAD_LAT   (LOAD_LAT),
    .IDX_W      (FW)
  ) u_src_1 (
    .i_sb        (r_sb),
    .i_src       (bus.src_1),
    .i_use       (1'b1),
    .o_hit       (w_hit_1),
    .o_idx       (w_idx_1),
    .o_too_early (w_early_1)
  );

  hazard_src_match #(
    .REG_ADDR_W (REG_ADDR_W),
    .STAGES     (STAGES),
    .LOAD_LAT   (LOAD_LAT),
    .IDX_W      (FW)
  ) u_src_2 (
    .i_sb        (r_sb),
    .i_src       (bus.src_2),
    .i_use       (bus.two_src),
    .o_hit       (w_hit_2),
    .o_idx       (w_idx_2),
    .o_too_early (w_early_2)
  );

`ifdef HAZARD_FORWARDING_EN
  // Forward from the youngest producer unless it is a load still short of LOAD_LAT.
  always_comb begin
    w_fwd_1 = FW'(FWD_RF);
    w_fwd_2 = FW'(FWD_RF);
    if (w_hit_1 && !w_early_1) w_fwd_1 = w_idx_1 + FW'(1);
    if (w_hit_2 && !w_early_2) w_fwd_2 = w_idx_2 + FW'(1);
    w_hazard = bus.id_valid && (w_early_1 || w_early_2);
  end
`else
  // Stall-only: any in-flight producer blocks ID until it reaches WB.
  always_comb begin
    w_fwd_1  = FW'(FWD_RF);
    w_fwd_2  = FW'(FWD_RF);
    w_hazard = bus.id_valid && (w_hit_1 || w_hit_2);
  end

  // Stage index and load-age flags only matter when forwarding is built in.
  logic w_unused_fwd;
  assign w_unused_fwd = ^{w_idx_1, w_idx_2, w_early_1, w_early_2};
`endif

  // What enters the EXE slot at the next edge: the ID instruction, or a bubble on a stall.
  always_comb begin
    w_id_entry = '0;
    if (bus.id_valid && !w_hazard) begin
      w_id_entry.valid   = 1'b1;
      w_id_entry.wb_en   = bus.id_wb_en;
      w_id_entry.dest    = SB_DEST_W'(bus.id_dest);
      w_id_entry.is_load = bus.id_mem_read;
    end
  end

  // Scoreboard follows the pipeline: clear on reset/flush, hold on freeze, else shift one stage.
  always_ff @(posedge clk) begin
    // NOTE: the scoreboard is only a few flops and its valid bits gate every match, so it is fully reset rather than left as uninitialised storage.
    if (rst || bus.flush) begin
      r_sb <= '0;
    end else if (!bus.freeze) begin
      // NOTE: non-blocking assignments make every stage read its neighbour's pre-edge value, which is what a shift register needs.
      for (int i = STAGES - 1; i >= 1; i--) begin
        r_sb[i] <= r_sb[i-1];
      end
      r_sb[0] <= w_id_entry;
    end
  end

  // Count cycles in which a bubble is actually inserted, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_count <= '0;
    end else if (w_hazard && !bus.freeze && !bus.flush && !(&r_stall_count)) begin
      r_stall_count <= r_stall_count + CNT_W'(1);
    end
  end

  assign bus.hazard_detected = w_hazard;
  assign bus.fwd_sel_1       = w_fwd_1;
  assign bus.fwd_sel_2       = w_fwd_2;
  assign bus.stall_count     = r_stall_count;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit (STAGES=2, LOAD_LAT=1, narrow CNT_W so
// saturation is reachable in a few cycles). Expected values follow the build:
// HAZARD_FORWARDING_EN defined selects the forwarding sequence, otherwise stall-only.
// Inputs change on the falling edge; outputs are sampled 2 ns later.
module tb_hazard_forward_unit;

  localparam int RW = 4;
  localparam int ST = 2;
  localparam int LL = 1;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  hazard_forward_unit_if #(.REG_ADDR_W(RW), .STAGES(ST), .CNT_W(CW)) bus ();

  hazard_forward_unit #(
    .REG_ADDR_W (RW),
    .STAGES     (ST),
    .LOAD_LAT   (LL),
    .CNT_W      (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: at the falling edge apply control and ID fields, then settle.
  task automatic step(input logic fz, input logic fl, input logic v, input logic wb,
                      input logic [RW-1:0] d, input logic ld, input logic [RW-1:0] s1,
                      input logic [RW-1:0] s2, input logic two);
    @(negedge clk);
    rst             = 1'b0;
    bus.freeze      = fz;
    bus.flush       = fl;
    bus.id_valid    = v;
    bus.id_wb_en    = wb;
    bus.id_dest     = d;
    bus.id_mem_read = ld;
    bus.src_1       = s1;
    bus.src_2       = s2;
    bus.two_src     = two;
    #2;
  endtask

  initial begin
    rst             = 1'b1;
    bus.freeze      = 1'b0;
    bus.flush       = 1'b0;
    bus.id_valid    = 1'b1;
    bus.id_wb_en    = 1'b0;
    bus.id_dest     = '0;
    bus.id_mem_read = 1'b0;
    bus.src_1       = '0;
    bus.src_2       = '0;
    bus.two_src     = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    check("reset_hazard", bus.hazard_detected, 0);
    check("reset_fwd1", bus.fwd_sel_1, 0);
    check("reset_fwd2", bus.fwd_sel_2, 0);
    check("reset_count", bus.stall_count, 0);

`ifdef HAZARD_FORWARDING_EN
    // ALU r3, then readers at EXE distance and MEM distance.
    step(0, 0, 1, 1, 3, 0, 0, 0, 0);
    check("alu_issue_hz", bus.hazard_detected, 0);
    step(0, 0, 1, 1, 8, 0, 3, 0, 0);
    check("alu_exe_hz", bus.hazard_detected, 0);
    check("alu_exe_fwd1", bus.fwd_sel_1, 1);
    step(0, 0, 1, 1, 4, 0, 3, 0, 0);
    check("alu_mem_fwd1", bus.fwd_sel_1, 2);
    // r4 in both EXE and MEM: youngest wins.
    step(0, 0, 1, 1, 4, 0, 0, 0, 0);
    check("no_dep_fwd1", bus.fwd_sel_1, 0);
    step(0, 0, 1, 0, 0, 0, 4, 4, 1);
    check("youngest_fwd1", bus.fwd_sel_1, 1);
    check("youngest_fwd2", bus.fwd_sel_2, 1);
    // Load r5, then src_2 use: one stall, then MEM forward.
    step(0, 0, 1, 1, 5, 1, 0, 0, 0);
    check("load_issue_hz", bus.hazard_detected, 0);
    step(0, 0, 1, 0, 0, 0, 0, 5, 1);
    check("load_use_hz", bus.hazard_detected, 1);
    check("load_use_fwd2", bus.fwd_sel_2, 0);
    check("load_use_cnt0", bus.stall_count, 0);
    step(0, 0, 1, 0, 0, 0, 0, 5, 1);
    check("load_mem_hz", bus.hazard_detected, 0);
    check("load_mem_fwd2", bus.fwd_sel_2, 2);
    check("load_use_cnt1", bus.stall_count, 1);
    // Same load-use shape with src_2 unused: no stall.
    step(0, 0, 1, 1, 5, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 5, 0);
    check("one_src_hz", bus.hazard_detected, 0);
    check("one_src_fwd2", bus.fwd_sel_2, 0);
    // Load r6, load-use stall held under freeze for 3 cycles.
    step(0, 0, 1, 1, 6, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 1, 1, 7, 0, 6, 0, 0);
      check("frz_hz", bus.hazard_detected, 1);
      check("frz_fwd1", bus.fwd_sel_1, 0);
      check("frz_cnt", bus.stall_count, 1);
    end
    step(0, 0, 1, 1, 7, 0, 6, 0, 0);
    check("unfrz_hz", bus.hazard_detected, 1);
    step(0, 0, 1, 1, 7, 0, 6, 0, 0);
    check("unfrz_drop_hz", bus.hazard_detected, 0);
    check("unfrz_fwd1", bus.fwd_sel_1, 2);
    check("unfrz_cnt", bus.stall_count, 2);
    // Flush during a pending load-use stall.
    step(0, 0, 1, 1, 9, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 9, 7, 1);
    check("flush_hz", bus.hazard_detected, 1);
    check("flush_fwd2", bus.fwd_sel_2, 2);
    step(0, 0, 1, 0, 0, 0, 9, 7, 1);
    check("post_flush_hz", bus.hazard_detected, 0);
    check("post_flush_fwd1", bus.fwd_sel_1, 0);
    check("post_flush_fwd2", bus.fwd_sel_2, 0);
    check("post_flush_cnt", bus.stall_count, 2);
`else
    // ALU r2 then reader of r2: stalls for both tracked stages.
    step(0, 0, 1, 1, 2, 0, 0, 0, 0);
    check("alu_issue_hz", bus.hazard_detected, 0);
    step(0, 0, 1, 1, 7, 0, 2, 0, 0);
    check("stall_exe_hz", bus.hazard_detected, 1);
    check("stall_exe_fwd1", bus.fwd_sel_1, 0);
    check("stall_exe_cnt", bus.stall_count, 0);
    step(0, 0, 1, 1, 7, 0, 2, 0, 0);
    check("stall_mem_hz", bus.hazard_detected, 1);
    check("stall_mem_cnt", bus.stall_count, 1);
    step(0, 0, 1, 1, 7, 0, 2, 0, 0);
    check("past_wb_hz", bus.hazard_detected, 0);
    check("past_wb_fwd1", bus.fwd_sel_1, 0);
    check("past_wb_cnt", bus.stall_count, 2);
    // src_2 only counts when two_src is set; entries with wb_en=0 never match.
    step(0, 0, 1, 0, 0, 0, 0, 7, 0);
    check("src2_unused_hz", bus.hazard_detected, 0);
    step(0, 0, 1, 0, 0, 0, 0, 7, 1);
    check("src2_used_hz", bus.hazard_detected, 1);
    step(0, 0, 1, 0, 0, 0, 0, 0, 0);
    check("no_wb_hz", bus.hazard_detected, 0);
    check("no_wb_cnt", bus.stall_count, 3);
    // Load r5, then invalid ID under freeze, then a 3-cycle frozen stall.
    step(0, 0, 1, 1, 5, 1, 0, 0, 0);
    check("load_issue_hz", bus.hazard_detected, 0);
    step(1, 0, 0, 1, 6, 0, 5, 0, 0);
    check("id_invalid_hz", bus.hazard_detected, 0);
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 1, 1, 6, 0, 5, 0, 0);
      check("frz_hz", bus.hazard_detected, 1);
      check("frz_cnt", bus.stall_count, 3);
    end
    step(0, 0, 1, 1, 6, 0, 5, 0, 0);
    check("unfrz_exe_hz", bus.hazard_detected, 1);
    step(0, 0, 1, 1, 6, 0, 5, 0, 0);
    check("unfrz_mem_hz", bus.hazard_detected, 1);
    check("unfrz_mem_cnt", bus.stall_count, 4);
    step(0, 0, 1, 1, 6, 0, 5, 0, 0);
    check("unfrz_drop_hz", bus.hazard_detected, 0);
    check("unfrz_drop_cnt", bus.stall_count, 5);
    // Flush with a stall pending.
    step(0, 1, 1, 0, 0, 0, 6, 0, 0);
    check("flush_hz", bus.hazard_detected, 1);
    step(0, 0, 1, 0, 0, 0, 6, 0, 0);
    check("post_flush_hz", bus.hazard_detected, 0);
    check("post_flush_fwd1", bus.fwd_sel_1, 0);
    check("post_flush_fwd2", bus.fwd_sel_2, 0);
    check("post_flush_cnt", bus.stall_count, 5);
    // Flush and freeze together: flush must clear the entries.
    step(0, 0, 1, 1, 9, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 9, 0, 0);
    check("flush_frz_hz", bus.hazard_detected, 1);
    step(0, 0, 1, 0, 0, 0, 9, 0, 0);
    check("flush_wins_hz", bus.hazard_detected, 0);
    check("flush_wins_cnt", bus.stall_count, 5);
    // Self-dependent writer of r10: period of 3 cycles with 2 stalls each, to saturation.
    step(0, 0, 1, 1, 10, 0, 10, 0, 0);
    check("sat_first_hz", bus.hazard_detected, 0);
    repeat (14) @(negedge clk);
    #2;
    check("sat_near_cnt", bus.stall_count, 14);
    check("sat_near_hz", bus.hazard_detected, 1);
    repeat (7) @(negedge clk);
    #2;
    check("sat_hold_cnt", bus.stall_count, 15);
    check("sat_enter_hz", bus.hazard_detected, 0);
    @(negedge clk);
    #2;
    check("pre_rst_hz", bus.hazard_detected, 1);
    // Reset in the middle of a stall.
    rst = 1'b1;
    step(0, 0, 1, 1, 10, 0, 10, 0, 0);
    check("mid_rst_hz", bus.hazard_detected, 0);
    check("mid_rst_fwd1", bus.fwd_sel_1, 0);
    check("mid_rst_cnt", bus.stall_count, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
